// File: rtl/reg_slice_skid.sv
// ============================================================================
// Module  : reg_slice_skid
// Brief   : Fully registered valid/ready slice with a one-entry skid buffer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_slice_skid #(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

   // State encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             w_in_fire;
   logic             w_out_fire;

   assign w_in_fire  = in_valid & in_ready_q;
   assign w_out_fire = out_valid_q & out_ready;

   always_comb begin
      state_d    = state_q;
      out_data_d = out_data_q;
      skid_d     = skid_q;
      if (clr) begin
         state_d    = EMPTY;
         out_data_d = RESET_VALUE;
         skid_d     = RESET_VALUE;
      end else begin
         case (state_q)
            EMPTY: begin
               if (w_in_fire) begin
                  state_d    = ONE;
                  out_data_d = in_data;
               end
            end
            ONE: begin
               if (w_in_fire && w_out_fire) begin
                  out_data_d = in_data;
               end else if (w_in_fire) begin
                  state_d = TWO;
                  skid_d  = in_data;
               end else if (w_out_fire) begin
                  state_d = EMPTY;
               end
            end
            TWO: begin
               if (w_out_fire) begin
                  state_d    = ONE;
                  out_data_d = skid_q;
               end
            end
            default: begin
               state_d = EMPTY;
            end
         endcase
      end
      // Handshake flags are precomputed from the next state so they leave as flops.
      in_ready_d  = (state_d != TWO);
      out_valid_d = (state_d != EMPTY);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         out_data_q  <= RESET_VALUE;
         skid_q      <= RESET_VALUE;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_data_q  <= out_data_d;
         skid_q      <= skid_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign occupancy = state_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_slice_skid.sv
// ============================================================================
// Module  : tb_reg_slice_skid
// Brief   : Scoreboard bench for reg_slice_skid, 32-bit and 1-bit instances.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_slice_skid;

   localparam logic [31:0] RV32 = 32'hDEAD_BEEF;
   localparam logic [0:0]  RV1  = 1'b1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic        out_ready = 1'b0;

   logic        in_ready32, out_valid32, in_ready1, out_valid1;
   logic [31:0] out_data32;
   logic [0:0]  out_data1;
   logic [1:0]  occ32, occ1;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: a FIFO of at most two words plus the "last seen" output.
   logic [31:0] exp_q[$];
   logic [31:0] m_last32 = RV32;
   logic        m_last1  = RV1;
   logic        m_ready  = 1'b0;
   bit          mon_en   = 1'b0;

   always #5 clk = ~clk;

   reg_slice_skid #(.WIDTH(32), .RESET_VALUE(RV32)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready32), .in_data(in_data),
      .out_valid(out_valid32), .out_ready(out_ready), .out_data(out_data32),
      .occupancy(occ32)
   );

   reg_slice_skid #(.WIDTH(1), .RESET_VALUE(RV1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data[0:0]),
      .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
      .occupancy(occ1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Monitor: compare DUT against the model, then advance the model by the
   // handshake that the upcoming rising edge will perform.
   always @(negedge clk) begin
      if (mon_en) begin
         logic [31:0] w;
         bit fi, fo;
         chk("in_ready32",  {31'd0, in_ready32},  {31'd0, m_ready});
         chk("in_ready1",   {31'd0, in_ready1},   {31'd0, m_ready});
         chk("out_valid32", {31'd0, out_valid32}, {31'd0, exp_q.size() > 0});
         chk("out_valid1",  {31'd0, out_valid1},  {31'd0, exp_q.size() > 0});
         chk("occupancy32", {30'd0, occ32}, exp_q.size());
         chk("occupancy1",  {30'd0, occ1},  exp_q.size());
         if (exp_q.size() > 0) begin
            chk("out_data32", out_data32, exp_q[0]);
            chk("out_data1",  {31'd0, out_data1}, {31'd0, exp_q[0][0]});
         end else begin
            chk("idle_data32", out_data32, m_last32);
            chk("idle_data1",  {31'd0, out_data1}, {31'd0, m_last1});
         end
         if (clr) begin
            exp_q.delete();
            m_last32 = RV32;
            m_last1  = RV1;
            m_ready  = 1'b1;
         end else begin
            fi = in_valid && m_ready;
            fo = (exp_q.size() > 0) && out_ready;
            if (fo) begin
               w = exp_q.pop_front();
               m_last32 = w;
               m_last1  = w[0];
            end
            if (fi) exp_q.push_back(in_data);
            m_ready = (exp_q.size() < 2);
         end
      end
   end

   task automatic cyc(input bit v, input logic [31:0] d, input bit r, input bit c);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      clr       = c;
      @(posedge clk);
      #1;
   endtask

   // Async reset asserted mid-cycle; outputs must drop without a clock edge.
   task automatic do_reset();
      mon_en = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_in_ready",  {31'd0, in_ready32},  32'd0);
      chk("rst_out_valid", {31'd0, out_valid32}, 32'd0);
      chk("rst_out_data",  out_data32, RV32);
      chk("rst_out_data1", {31'd0, out_data1}, {31'd0, RV1});
      chk("rst_occupancy", {30'd0, occ32}, 32'd0);
      exp_q.delete();
      m_last32 = RV32;
      m_last1  = RV1;
      m_ready  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      mon_en = 1'b1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int bias_v, bias_r;
      // Reset with a producer already presenting data.
      in_valid = 1'b1;
      in_data  = 32'h99;
      @(posedge clk);
      #1;
      do_reset();
      chk("post_rel_ready", {31'd0, in_ready32}, 32'd0);
      cyc(1, 32'h99, 0, 0);
      chk("first_edge_ready", {31'd0, in_ready32}, 32'd1);
      chk("first_edge_occ",   {30'd0, occ32}, 32'd0);
      cyc(0, 0, 1, 0);

      // Streaming 0x01..0x10
      for (int i = 1; i <= 16; i++) cyc(1, i, 1, 0);
      chk("stream_occ", {30'd0, occ32}, 32'd1);
      chk("stream_last", out_data32, 32'h10);
      cyc(0, 0, 1, 0);

      // Backpressure: A1, A2 fill, A3 ignored while full
      cyc(1, 32'hA1, 0, 0);
      cyc(1, 32'hA2, 0, 0);
      cyc(1, 32'hA3, 0, 0);
      chk("bp_occ",   {30'd0, occ32}, 32'd2);
      chk("bp_ready", {31'd0, in_ready32}, 32'd0);
      chk("bp_data",  out_data32, 32'hA1);
      cyc(0, 0, 1, 0);
      chk("bp_drain1", out_data32, 32'hA2);
      chk("bp_ready_back", {31'd0, in_ready32}, 32'd1);
      cyc(0, 0, 1, 0);

      // Simultaneous in/out in ONE
      cyc(1, 32'h44, 0, 0);
      cyc(1, 32'h55, 1, 0);
      chk("sim_data", out_data32, 32'h55);
      chk("sim_occ",  {30'd0, occ32}, 32'd1);
      cyc(0, 0, 1, 0);

      // clr while in TWO with a word presented
      cyc(1, 32'h66, 0, 0);
      cyc(1, 32'h67, 0, 0);
      cyc(1, 32'h77, 0, 1);
      chk("clr_valid", {31'd0, out_valid32}, 32'd0);
      chk("clr_data",  out_data32, RV32);
      chk("clr_ready", {31'd0, in_ready32}, 32'd1);
      cyc(0, 0, 1, 0);

      // clr held: every word discarded
      for (int i = 0; i < 4; i++) cyc(1, 32'h80 + i, 1, 1);
      chk("clr_hold_occ", {30'd0, occ32}, 32'd0);

      // Random traffic with shifting valid/ready densities
      bias_v = 50;
      bias_r = 50;
      for (int i = 0; i < 10000; i++) begin
         if (i % 1000 == 0) begin
            bias_v = $urandom_range(10, 100);
            bias_r = $urandom_range(10, 100);
         end
         if (i == 5000) do_reset();
         cyc($urandom_range(1, 100) <= bias_v, $urandom,
             $urandom_range(1, 100) <= bias_r, $urandom_range(0, 63) == 0);
      end

      // Drain remaining words
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);
      chk("final_empty", {30'd0, occ32}, 32'd0);
      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
